serial_add_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a `WIDTH`-bit operand pair `DIGIT` bits per clock. It uses a start/busy/done handshake and reports the result, carry/borrow out and signed overflow. It is the sequential, width-generalised successor of the single-bit full adder/subtractor cell, and it sits beside the datapath as a small-area arithmetic unit.

---
 rtl/serial_add_sub.sv | 125 ++++++++++++
 tb/tb_serial_add_sub.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: processes a WIDTH-bit operand pair DIGIT bits per
// clock, LSB digit first, with a start/busy/done handshake, carry/borrow and overflow.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRAP,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q;
  logic              sub_q;
  logic              a_msb_q, b_msb_q;
  logic              cout_q, ovf_q;
  logic [DIGIT:0]    dsum;
  logic              accept;
  logic              last_step;

  // Subtraction runs as a + ~b + !carry_in, so b_q and b_msb_q hold the effective
  // (possibly inverted) operand and the overflow test is the same for both modes.
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (cnt_q == CW'(N - 1));
  assign dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_d = WRAP;
      end
      WRAP: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d = res_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) res_d[i*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= carry_in ^ sub;
      sub_q   <= sub;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1] ^ sub;
    end else if (state_q == RUN) begin
      cnt_q   <= cnt_q + CW'(1);
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= dsum[DIGIT];
      res_q   <= res_d;
    end else if (state_q == WRAP) begin
      // Final carry of a + ~b + !cin is the inverse of the borrow.
      cout_q <= carry_q ^ sub_q;
      ovf_q  <= (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: an 8-bit/1-bit-digit instance for the handshake
// and arithmetic corner cases, and a 16-bit/4-bit-digit instance against a model.
module tb_serial_add_sub;

  logic        clk;
  logic        rst_n;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  res8;

  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, ov16;
  logic [15:0] res16;

  int n_cmp;
  int n_fail;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .carry_in(cin8), .busy(busy8), .done(done8), .result(res8),
    .carry_out(co8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .carry_in(cin16), .busy(busy16), .done(done16), .result(res16),
    .carry_out(co16), .overflow(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request so it is sampled on the next rising edge, then drop start.
  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    start8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int busyc);
    lat   = 0;
    busyc = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) busyc++;
    end
  endtask

  task automatic issue16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    start16 = 1'b1; sub16 = s; a16 = a; b16 = b; cin16 = c;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic wait_done16(output int lat, output int busyc);
    lat   = 0;
    busyc = busy16 ? 1 : 0;
    while (done16 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy16) busyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy8, done8, res8, co8, ov8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs8: got busy=%b done=%b res=%h co=%b ov=%b required all 0",
               busy8, done8, res8, co8, ov8);
    end
    n_cmp++;
    if ({busy16, done16, res16, co16, ov16} !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset_outputs16: got busy=%b done=%b res=%h co=%b ov=%b required all 0",
               busy16, done16, res16, co16, ov16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    int lat, busyc;
    issue8(1'b0, 8'h3C, 8'h45, 1'b0);
    wait_done8(lat, busyc);
    n_cmp++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL add_latency: got %0d required 9", lat);
    end
    n_cmp++;
    if (busyc !== 8) begin
      n_fail++; $display("FAIL add_busy_cycles: got %0d required 8", busyc);
    end
    n_cmp++;
    if ({res8, co8, ov8} !== {8'h81, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_3C_45: got res=%h co=%b ov=%b required res=81 co=0 ov=1",
               res8, co8, ov8);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b0) begin
      n_fail++; $display("FAIL done_single_pulse: got %b required 0", done8);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy8, res8, co8, ov8} !== {1'b0, 8'h81, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL output_hold: got busy=%b res=%h co=%b ov=%b required busy=0 res=81 co=0 ov=1",
               busy8, res8, co8, ov8);
    end
  endtask

  task automatic test_sub_borrow;
    int lat, busyc;
    issue8(1'b1, 8'h10, 8'h20, 1'b0);
    wait_done8(lat, busyc);
    n_cmp++;
    if ({res8, co8, ov8} !== {8'hF0, 1'b1, 1'b0} || lat !== 9) begin
      n_fail++;
      $display("FAIL sub_10_20: got res=%h co=%b ov=%b lat=%0d required res=F0 co=1 ov=0 lat=9",
               res8, co8, ov8, lat);
    end
    @(posedge clk); #1;
    issue8(1'b1, 8'h80, 8'h01, 1'b0);
    wait_done8(lat, busyc);
    n_cmp++;
    if ({res8, co8, ov8} !== {8'h7F, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_80_01: got res=%h co=%b ov=%b required res=7F co=0 ov=1",
               res8, co8, ov8);
    end
  endtask

  task automatic test_carry_wrap;
    int lat, busyc;
    @(posedge clk); #1;
    issue8(1'b0, 8'hFF, 8'h00, 1'b1);
    wait_done8(lat, busyc);
    n_cmp++;
    if ({res8, co8, ov8} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_FF_00_cin: got res=%h co=%b ov=%b required res=00 co=1 ov=0",
               res8, co8, ov8);
    end
    @(posedge clk); #1;
    issue8(1'b1, 8'h00, 8'h00, 1'b1);
    wait_done8(lat, busyc);
    n_cmp++;
    if ({res8, co8, ov8} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_00_00_bin: got res=%h co=%b ov=%b required res=FF co=1 ov=0",
               res8, co8, ov8);
    end
  endtask

  task automatic test_start_ignored;
    int lat, busyc;
    @(posedge clk); #1;
    issue8(1'b0, 8'h3C, 8'h45, 1'b0);
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1; lat++;
    end
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
    @(posedge clk); #1; lat++;
    start8 = 1'b0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat !== 9 || {res8, co8, ov8} !== {8'h81, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_in_run: got lat=%0d res=%h co=%b ov=%b required lat=9 res=81 co=0 ov=1",
               lat, res8, co8, ov8);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busyc;
    @(posedge clk); #1;
    issue8(1'b1, 8'h10, 8'h20, 1'b0);
    wait_done8(lat, busyc);
    n_cmp++;
    if (res8 !== 8'hF0 || co8 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got res=%h co=%b required res=F0 co=1", res8, co8);
    end
    // Request during the done cycle itself.
    issue8(1'b0, 8'h7F, 8'h01, 1'b0);
    n_cmp++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got busy=%b done=%b required busy=1 done=0", busy8, done8);
    end
    wait_done8(lat, busyc);
    n_cmp++;
    if (lat !== 9 || {res8, co8, ov8} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d res=%h co=%b ov=%b required lat=9 res=80 co=0 ov=1",
               lat, res8, co8, ov8);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, busyc;
    int seen;
    @(posedge clk); #1;
    issue8(1'b0, 8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, res8, co8, ov8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%b done=%b res=%h co=%b ov=%b required all 0",
               busy8, done8, res8, co8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL no_done_after_reset: got %0d active cycles required 0", seen);
    end
    issue8(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_done8(lat, busyc);
    n_cmp++;
    if (lat !== 9 || {res8, co8, ov8} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_op: got lat=%0d res=%h co=%b ov=%b required lat=9 res=00 co=1 ov=0",
               lat, res8, co8, ov8);
    end
  endtask

  task automatic test_wide_digits;
    int lat, busyc;
    logic        s, c;
    logic [15:0] a, b, er;
    logic [16:0] full;
    logic        eco, eov;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        s = 1'b1; a = 16'h8000; b = 16'h0001; c = 1'b0;
      end else if (i == 1) begin
        s = 1'b0; a = 16'hFFFF; b = 16'h0000; c = 1'b1;
      end else begin
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      if (!s) full = {1'b0, a} + {1'b0, b} + {16'h0000, c};
      else    full = {1'b0, a} - {1'b0, b} - {16'h0000, c};
      er  = full[15:0];
      eco = full[16];
      eov = s ? (a[15] != b[15]) && (er[15] != a[15])
              : (a[15] == b[15]) && (er[15] != a[15]);
      @(posedge clk); #1;
      issue16(s, a, b, c);
      wait_done16(lat, busyc);
      n_cmp++;
      if (lat !== 5 || busyc !== 4) begin
        n_fail++;
        $display("FAIL wide_timing[%0d]: got lat=%0d busy=%0d required lat=5 busy=4",
                 i, lat, busyc);
      end
      n_cmp++;
      if ({res16, co16, ov16} !== {er, eco, eov}) begin
        n_fail++;
        $display("FAIL wide_result[%0d]: sub=%b a=%h b=%h cin=%b got res=%h co=%b ov=%b required res=%h co=%b ov=%b",
                 i, s, a, b, c, res16, co16, ov16, er, eco, eov);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_borrow();
    test_carry_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_wide_digits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
